feature_map_streamer: RTL and testbench
=======================================

Name: feature_map_streamer

Overview:
- Reads a stored feature map from a single-port BRAM.
- Emits it as a raster pixel stream: data_valid_out, pixel_data_out, hcount_out, vcount_out. This is the same stream interface the convolution layers consume.
- It is the producer end of the stream, sitting between a feature-map buffer and a convolution layer's input.
- Pixel issue is throttled by PIXEL_GAP so that multi-cycle row-serial convolutions keep up.

Parameters:
- PIXEL_W, 21, signed pixel width (bits).
- H_SIZE, 32, pixels per row.
- V_SIZE, 32, rows per map.
- ADDR_W, 16, BRAM address width.
- READ_LATENCY, 2, cycles from bram_addr_out to valid bram_data_in (>=1).
- PIXEL_GAP, 8, cycles between successive read issues (>=1; 1 = back-to-back).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous active-low reset.
- start_in  input  1  one-cycle pulse; begins streaming one map.
- base_addr_in  input  ADDR_W  BRAM address of pixel (0,0); latched on accepted start.
- abort_in  input  1  synchronous abort; flush and return to idle.
- bram_addr_out  output  ADDR_W  BRAM read address.
- bram_en_out  output  1  BRAM read enable, high only on issue cycles.
- bram_data_in  input  PIXEL_W  signed BRAM read data.
- data_valid_out  output  1  pixel valid strobe.
- pixel_data_out  output  PIXEL_W  signed pixel.
- hcount_out  output  5  column of the pixel.
- vcount_out  output  5  row of the pixel.
- busy_out  output  1  high from accepted start until done.
- done_out  output  1  one-cycle pulse after the last pixel is emitted.

Behaviour:
- Reset (rst_in low, async): FSM to IDLE; tag pipe cleared. All outputs 0: data_valid_out, pixel_data_out, hcount_out, vcount_out, bram_addr_out, bram_en_out, busy_out, done_out.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - start_in=1 latches base_addr_in, clears h/v counters and the gap counter, and moves to ISSUE.
  - busy_out goes high the next cycle.
- ISSUE:
  - When the gap counter is 0: bram_en_out=1, bram_addr_out = base + v*H_SIZE + h.
  - Address is computed incrementally (running offset), with no multiplier.
  - The tag {valid=1, h, v} is pushed into a READ_LATENCY-deep tag pipe.
  - h increments; on h=H_SIZE-1, h wraps to 0 and v increments.
  - The gap counter reloads to PIXEL_GAP-1 and decrements to 0.
  - After issuing (H_SIZE-1, V_SIZE-1), go to DRAIN.
- DRAIN: no issues; wait until the tag pipe is empty, then go to FINISH.
- FINISH:
  - done_out=1 for exactly one cycle; busy_out drops in the same cycle. Return to IDLE.
  - done_out rises the cycle after the final data_valid_out.
- Output timing:
  - Pixel outputs are registered.
  - For a read issued at cycle t, data_valid_out/pixel_data_out/hcount_out/vcount_out update at t+READ_LATENCY+1.
  - pixel_data_out is the bram_data_in sampled at t+READ_LATENCY.
  - data_valid_out is high exactly one cycle per pixel.
  - pixel_data_out, hcount_out and vcount_out hold their last values when not valid.
- Throughput:
  - PIXEL_GAP=1 gives one pixel per cycle.
  - Otherwise exactly PIXEL_GAP cycles separate consecutive valids.
- Start handling:
  - start_in while busy is ignored; the stream is unchanged.
  - start_in coincident with FINISH is ignored.
- Abort:
  - abort_in in ISSUE or DRAIN clears the tag pipe and returns the FSM to IDLE next cycle.
  - No further data_valid_out, no done_out, busy_out drops.
  - abort_in in IDLE is a no-op. abort has priority over start.
- Address arithmetic: base + offset truncated to ADDR_W (wraps modulo 2^ADDR_W; no error).
- hcount and vcount are 5 bits, so H_SIZE and V_SIZE must be <=32. The sizes are checked by elaboration-time assertions.
- Total pixels per map: H_SIZE*V_SIZE, in raster order: row 0 columns 0..H_SIZE-1 first.

Decomposition:
- Package cnn_stream_pkg holds:
  - PIXEL_W default;
  - FMAP_H and FMAP_V;
  - COUNT_W=5;
  - the streamer_state_t enum {IDLE, ISSUE, DRAIN, FINISH};
  - a stream_tag_t struct {valid, hcount, vcount}.
- Sub-module stream_tag_pipe: parameterized DEPTH shift register of stream_tag_t with synchronous flush and async active-low reset. It is used for the READ_LATENCY alignment.

Test Plan:
- Memory model with READ_LATENCY=2, data = address-base; base=100, PIXEL_GAP=1; start pulse. -> Expect:
  - 1024 valids on consecutive cycles;
  - first valid 3 cycles after the first bram_en_out, pixel 0, h=0, v=0;
  - last valid pixel 1023, h=31, v=31;
  - done_out the next cycle.
- PIXEL_GAP=8 -> valids exactly 8 cycles apart; bram_addr_out sequence 100,101,...; pixel at (h=5,v=2) = 69.
- Re-pulse start_in at pixel 300 -> no restart; stream continues to 1023; single done_out.
- abort_in at pixel 500 -> at most READ_LATENCY+1 further cycles with no valid; busy_out low; no done_out. A subsequent start streams a full map from pixel 0.
- rst_in low mid-stream (async, between edges) -> all outputs 0 immediately. After release the FSM is IDLE until start.
- base=0xFFF0, ADDR_W=16 -> address wraps to 0x0000 after 0xFFFF; data matches the modular address.

Source files
------------

// File: rtl/cnn_stream_pkg.sv
// Shared types for the CNN pixel-stream blocks.
// Map geometry defaults, FSM states and the read-tag bundle.
package cnn_stream_pkg;

   localparam int DEF_PIXEL_W = 21;
   localparam int FMAP_H      = 32;
   localparam int FMAP_V      = 32;
   localparam int COUNT_W     = 5;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      FINISH
   } streamer_state_t;

   typedef struct packed {
      logic               valid;
      logic [COUNT_W-1:0] hcount;
      logic [COUNT_W-1:0] vcount;
   } stream_tag_t;

endpackage

// File: rtl/feature_map_streamer_if.sv
// Raster pixel stream shared by the streamer and the convolution layers.
// The streamer drives it as master; a consumer attaches as slave.
interface feature_map_streamer_if #(
   parameter int PIXEL_W = cnn_stream_pkg::DEF_PIXEL_W
);

   logic                                 data_valid_out;
   logic signed [PIXEL_W-1:0]            pixel_data_out;
   logic [cnn_stream_pkg::COUNT_W-1:0]   hcount_out;
   logic [cnn_stream_pkg::COUNT_W-1:0]   vcount_out;

   modport master (
      output data_valid_out,
      output pixel_data_out,
      output hcount_out,
      output vcount_out
   );

   modport slave (
      input data_valid_out,
      input pixel_data_out,
      input hcount_out,
      input vcount_out
   );

endinterface

// File: rtl/stream_tag_pipe.sv
// Fixed-depth shift register carrying read tags alongside BRAM latency.
// Flush clears every stage so no in-flight read ever surfaces.
module stream_tag_pipe
   import cnn_stream_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        flush_in,
   input  stream_tag_t tag_in,
   output stream_tag_t tag_out,
   output logic        empty_out
);

   stream_tag_t pipe_q [DEPTH];

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else if (flush_in) begin
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   always_comb begin
      empty_out = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         if (pipe_q[i].valid) empty_out = 1'b0;
      end
   end

   assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/feature_map_streamer.sv
// Streams a stored feature map out of BRAM as a throttled raster.
// Read tags ride a latency-matched pipe so data and position line up.
module feature_map_streamer
   import cnn_stream_pkg::*;
#(
   parameter int PIXEL_W      = DEF_PIXEL_W,
   parameter int H_SIZE       = FMAP_H,
   parameter int V_SIZE       = FMAP_V,
   parameter int ADDR_W       = 16,
   parameter int READ_LATENCY = 2,
   parameter int PIXEL_GAP    = 8
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      start_in,
   input  logic [ADDR_W-1:0]         base_addr_in,
   input  logic                      abort_in,
   output logic [ADDR_W-1:0]         bram_addr_out,
   output logic                      bram_en_out,
   input  logic signed [PIXEL_W-1:0] bram_data_in,
   feature_map_streamer_if.master    pix,
   output logic                      busy_out,
   output logic                      done_out
);

   localparam int GAP_W = (PIXEL_GAP > 1) ? $clog2(PIXEL_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(PIXEL_GAP - 1);
   localparam logic [COUNT_W-1:0] H_LAST = COUNT_W'(H_SIZE - 1);
   localparam logic [COUNT_W-1:0] V_LAST = COUNT_W'(V_SIZE - 1);

   if (H_SIZE < 1 || H_SIZE > 2**COUNT_W ||
       V_SIZE < 1 || V_SIZE > 2**COUNT_W ||
       READ_LATENCY < 1 || PIXEL_GAP < 1) begin : g_bad_cfg
      $error("feature_map_streamer: unsupported parameters");
   end

   streamer_state_t    state_q, state_d;
   logic [ADDR_W-1:0]  base_q, base_d;
   logic [ADDR_W-1:0]  off_q, off_d;
   logic [COUNT_W-1:0] h_q, h_d;
   logic [COUNT_W-1:0] v_q, v_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               issue, flush, pipe_empty;
   stream_tag_t        tag_d, tag_out;

   logic                      valid_q;
   logic signed [PIXEL_W-1:0] pix_q;
   logic [COUNT_W-1:0]        hc_q, vc_q;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= IDLE;
         base_q  <= '0;
         off_q   <= '0;
         h_q     <= '0;
         v_q     <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         off_q   <= off_d;
         h_q     <= h_d;
         v_q     <= v_d;
         gap_q   <= gap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      off_d   = off_q;
      h_d     = h_q;
      v_d     = v_q;
      gap_d   = gap_q;
      flush   = 1'b0;
      tag_d   = '0;
      issue   = (state_q == ISSUE) && (gap_q == '0) && !abort_in;
      unique case (state_q)
         IDLE: begin
            if (start_in && !abort_in) begin
               base_d  = base_addr_in;
               off_d   = '0;
               h_d     = '0;
               v_d     = '0;
               gap_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (abort_in) begin
               flush   = 1'b1;
               state_d = IDLE;
            end else if (gap_q != '0) begin
               gap_d = gap_q - 1'b1;
            end else begin
               tag_d = '{valid: 1'b1, hcount: h_q, vcount: v_q};
               off_d = off_q + 1'b1;
               gap_d = GAP_RELOAD;
               if (h_q == H_LAST) begin
                  h_d = '0;
                  if (v_q == V_LAST) state_d = DRAIN;
                  else v_d = v_q + 1'b1;
               end else begin
                  h_d = h_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (abort_in) begin
               flush   = 1'b1;
               state_d = IDLE;
            end else if (pipe_empty) begin
               state_d = FINISH;
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   stream_tag_pipe #(
      .DEPTH(READ_LATENCY)
   ) u_tag_pipe (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .flush_in (flush),
      .tag_in   (tag_d),
      .tag_out  (tag_out),
      .empty_out(pipe_empty)
   );

   // An abort also kills the read landing this cycle.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         valid_q <= 1'b0;
         pix_q   <= '0;
         hc_q    <= '0;
         vc_q    <= '0;
      end else begin
         valid_q <= tag_out.valid && !flush;
         if (tag_out.valid && !flush) begin
            pix_q <= bram_data_in;
            hc_q  <= tag_out.hcount;
            vc_q  <= tag_out.vcount;
         end
      end
   end

   assign bram_addr_out      = base_q + off_q;
   assign bram_en_out        = issue;
   assign busy_out           = (state_q == ISSUE) || (state_q == DRAIN);
   assign done_out           = (state_q == FINISH);
   assign pix.data_valid_out = valid_q;
   assign pix.pixel_data_out = pix_q;
   assign pix.hcount_out     = hc_q;
   assign pix.vcount_out     = vc_q;

endmodule

// File: tb/tb_feature_map_streamer.sv
// Random-base bench for feature_map_streamer with a raster reference model.
// Two instances cover back-to-back and PIXEL_GAP=8 throttled streaming.
module tb_feature_map_streamer;

   localparam int NPIX = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b1;
   logic start1 = 1'b0, start8 = 1'b0;
   logic abort1 = 1'b0, abort8 = 1'b0;
   logic [15:0] base1 = '0, base8 = '0;
   logic [15:0] a1, a8;
   logic en1, en8, busy1, busy8, done1, done8;
   logic signed [20:0] bd1, bd8;

   feature_map_streamer_if #(.PIXEL_W(21)) pif1 ();
   feature_map_streamer_if #(.PIXEL_W(21)) pif8 ();

   feature_map_streamer #(
      .PIXEL_W(21), .H_SIZE(32), .V_SIZE(32), .ADDR_W(16),
      .READ_LATENCY(2), .PIXEL_GAP(1)
   ) u_dut1 (
      .clk_in(clk), .rst_in(rst_n), .start_in(start1),
      .base_addr_in(base1), .abort_in(abort1),
      .bram_addr_out(a1), .bram_en_out(en1), .bram_data_in(bd1),
      .pix(pif1), .busy_out(busy1), .done_out(done1)
   );

   feature_map_streamer #(
      .PIXEL_W(21), .H_SIZE(32), .V_SIZE(32), .ADDR_W(16),
      .READ_LATENCY(2), .PIXEL_GAP(8)
   ) u_dut8 (
      .clk_in(clk), .rst_in(rst_n), .start_in(start8),
      .base_addr_in(base8), .abort_in(abort8),
      .bram_addr_out(a8), .bram_en_out(en8), .bram_data_in(bd8),
      .pix(pif8), .busy_out(busy8), .done_out(done8)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int base_m [2];
   int idx [2];
   int iss [2];
   int first_en [2];
   int last_v [2];
   int dones [2];

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: two-cycle read, word = offset of address from base.
   logic signed [20:0] m1 [2];
   logic signed [20:0] m2 [2];
   always @(posedge clk) begin
      m1[0] <= en1 ? 21'((int'(a1) - base_m[0]) & 'hFFFF) : 21'($urandom);
      m1[1] <= en8 ? 21'((int'(a8) - base_m[1]) & 'hFFFF) : 21'($urandom);
      m2[0] <= m1[0];
      m2[1] <= m1[1];
   end
   assign bd1 = m2[0];
   assign bd8 = m2[1];

   task automatic mon(input int k, input logic v, input logic signed [20:0] px,
                      input logic [4:0] h, input logic [4:0] vc, input logic en,
                      input logic [15:0] a, input logic busy, input logic done);
      string s = (k == 0) ? "_g1" : "_g8";
      int gap = (k == 0) ? 1 : 8;
      if (en) begin
         if (iss[k] == 0) first_en[k] = cyc;
         chk({"addr", s}, a, (base_m[k] + iss[k]) & 'hFFFF);
         if (iss[k] == 16 && base_m[k] == 'hFFF0) chk({"wrap_addr", s}, a, 0);
         iss[k]++;
      end
      if (v) begin
         if (idx[k] == 0) chk({"first_lat", s}, cyc - first_en[k], 3);
         else chk({"spacing", s}, cyc - last_v[k], gap);
         chk({"pixel", s}, px, idx[k]);
         chk({"hcount", s}, h, idx[k] % 32);
         chk({"vcount", s}, vc, idx[k] / 32);
         if (h == 5 && vc == 2) chk({"px_5_2", s}, px, 69);
         idx[k]++;
         last_v[k] = cyc;
      end
      if (done) begin
         chk({"done_delay", s}, cyc - last_v[k], 1);
         chk({"done_count", s}, idx[k], NPIX);
         chk({"done_busy", s}, busy, 0);
         dones[k]++;
      end
   endtask

   always @(negedge clk) begin
      mon(0, pif1.data_valid_out, pif1.pixel_data_out, pif1.hcount_out,
          pif1.vcount_out, en1, a1, busy1, done1);
      mon(1, pif8.data_valid_out, pif8.pixel_data_out, pif8.hcount_out,
          pif8.vcount_out, en8, a8, busy8, done8);
   end

   task automatic pulse(input int k, input logic [15:0] b, input bit accept);
      @(posedge clk); #1;
      if (accept) begin
         base_m[k] = int'(b);
         idx[k] = 0;
         iss[k] = 0;
      end
      if (k == 0) begin start1 = 1'b1; base1 = b; end
      else begin start8 = 1'b1; base8 = b; end
      @(posedge clk); #1;
      start1 = 1'b0;
      start8 = 1'b0;
      chk(k == 0 ? "busy_after_start_g1" : "busy_after_start_g8",
          k == 0 ? busy1 : busy8, 1);
   endtask

   task automatic wait_idx(input int k, input int target, input int budget);
      int n = 0;
      while (idx[k] < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk("reach_idx", idx[k] >= target, 1);
   endtask

   task automatic wait_done(input int k, input int budget);
      int d0 = dones[k];
      int n = 0;
      while (dones[k] == d0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      repeat (20) @(posedge clk);
      chk(k == 0 ? "single_done_g1" : "single_done_g8", dones[k] - d0, 1);
   endtask

   task automatic chk_outputs_zero(input string s);
      chk({s, "_valid"}, pif1.data_valid_out, 0);
      chk({s, "_pixel"}, pif1.pixel_data_out, 0);
      chk({s, "_h"}, pif1.hcount_out, 0);
      chk({s, "_v"}, pif1.vcount_out, 0);
      chk({s, "_addr"}, a1, 0);
      chk({s, "_en"}, en1, 0);
      chk({s, "_busy"}, busy1, 0);
      chk({s, "_done"}, done1, 0);
   endtask

   initial begin
      int nv, nd;
      logic [15:0] b;
      for (int k = 0; k < 2; k++) begin
         base_m[k] = 0; idx[k] = 0; iss[k] = 0;
         first_en[k] = 0; last_v[k] = 0; dones[k] = 0;
      end
      #2 rst_n = 1'b0;
      #1 chk_outputs_zero("reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Throttled map on the gap-8 instance runs alongside the tests below.
      pulse(1, 16'd100, 1'b1);
      pulse(0, 16'd100, 1'b1);
      wait_idx(0, 300, 2000);
      pulse(0, 16'd555, 1'b0);
      wait_done(0, 2000);

      wait_done(1, 10000);

      b = 16'($urandom_range(0, 60000));
      pulse(0, b, 1'b1);
      wait_idx(0, 500, 2000);
      @(posedge clk); #1 abort1 = 1'b1;
      @(posedge clk); #1 abort1 = 1'b0;
      chk("abort_busy", busy1, 0);
      nv = 0; nd = 0;
      repeat (20) begin
         @(negedge clk);
         nv += int'(pif1.data_valid_out);
         nd += int'(done1);
      end
      chk("abort_valids", nv, 0);
      chk("abort_dones", nd, 0);

      b = 16'($urandom_range(0, 60000));
      pulse(0, b, 1'b1);
      wait_done(0, 2000);

      b = 16'($urandom_range(0, 60000));
      pulse(0, b, 1'b1);
      wait_idx(0, 100, 2000);
      @(posedge clk); #3 rst_n = 1'b0;
      #1 chk_outputs_zero("async_rst");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      nv = 0;
      repeat (10) begin
         @(negedge clk);
         nv += int'(pif1.data_valid_out) + int'(en1) + int'(busy1);
      end
      chk("idle_after_rst", nv, 0);

      pulse(0, 16'hFFF0, 1'b1);
      wait_done(0, 2000);
      chk("wrap_issues", iss[0], NPIX);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
